// File: rtl/instr_loader.sv
// Byte-stream instruction loader: packs big-endian 32-bit words and writes them to instruction memory from address 0.
// Optional feature: define OPCODE_CHECK_EN to reject words whose opcode is neither R-type nor addi.
module instr_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W+1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_t;

    localparam logic [31:0]     END_MARKER = 32'hFFFF_FFFF;
    localparam logic [ADDR_W:0] LAST_CNT   = {1'b0, {ADDR_W{1'b1}}};

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [ADDR_W:0]     word_cnt_reg, word_cnt_next;
    logic [1:0]          byte_idx_reg, byte_idx_next;
    logic [31:0]         word_reg, word_next;
    logic                byte_accept;
    logic                is_marker;
    logic                last_word;
    logic                mem_we;

    assign byte_accept = (state_reg == LOAD) && byte_valid_i;
    assign is_marker   = (word_reg == END_MARKER);
    assign last_word   = (word_cnt_reg == LAST_CNT);

    // Each lane captures the incoming byte only when the byte index selects it (index 0 -> MSB).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam int LO = 8 * (3 - gi);
            assign word_next[LO +: 8] = (byte_accept && (byte_idx_reg == 2'(gi)))
                                        ? byte_i : word_reg[LO +: 8];
        end
    endgenerate

`ifdef OPCODE_CHECK_EN
    logic err_reg, err_next;
    logic opcode_ok;

    assign opcode_ok = (word_reg[31:26] == 6'b000000) || (word_reg[31:26] == 6'b001000);
    assign err_o     = err_reg;
`else
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            word_cnt_reg <= '0;
            byte_idx_reg <= '0;
            word_reg     <= '0;
`ifdef OPCODE_CHECK_EN
            err_reg      <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            word_cnt_reg <= word_cnt_next;
            byte_idx_reg <= byte_idx_next;
            word_reg     <= word_next;
`ifdef OPCODE_CHECK_EN
            err_reg      <= err_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        word_cnt_next = word_cnt_reg;
        byte_idx_next = byte_idx_reg;
        mem_we        = 1'b0;
`ifdef OPCODE_CHECK_EN
        err_next      = err_reg;
`endif
        case (state_reg)
            IDLE, DONE: begin
                if (start_i) begin
                    state_next    = LOAD;
                    addr_next     = '0;
                    word_cnt_next = '0;
                    byte_idx_next = '0;
`ifdef OPCODE_CHECK_EN
                    err_next      = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (byte_accept) begin
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                if (is_marker) begin
                    state_next = DONE;
`ifdef OPCODE_CHECK_EN
                end else if (!opcode_ok) begin
                    err_next   = 1'b1;
                    state_next = DONE;
`endif
                end else begin
                    mem_we        = 1'b1;
                    addr_next     = addr_reg + 1'b1;
                    word_cnt_next = word_cnt_reg + 1'b1;
                    // Filling the last slot ends the load; the address wraps back to 0.
                    state_next    = last_word ? DONE : LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign byte_ready_o = (state_reg == LOAD);
    assign mem_we_o     = mem_we;
    assign mem_addr_o   = {addr_reg, 2'b00};
    assign mem_data_o   = word_reg;
    assign word_cnt_o   = word_cnt_reg;
    assign busy_o       = (state_reg == LOAD) || (state_reg == WRITE);
    assign done_o       = (state_reg == DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed scenarios plus randomized streams against a word-level model.
module tb_instr_loader;

    localparam int ADDR_W = 2;
    localparam int CAP    = 1 << ADDR_W;
`ifdef OPCODE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic              start_i = 1'b0;
    logic [7:0]        byte_i = 8'h00;
    logic              byte_valid_i = 1'b0;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W+1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic [ADDR_W:0]   word_cnt_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .word_cnt_o   (word_cnt_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int to_cnt = 0;
    int consec_we = 0;
    int stray_we = 0;
    logic prev_we = 1'b0;
    logic [ADDR_W+1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];

    // Write monitor: records every memory write and flags back-to-back or out-of-load strobes.
    always @(negedge clk) begin
        if (mem_we_o) begin
            wr_addr_q.push_back(mem_addr_o);
            wr_data_q.push_back(mem_data_o);
            if (prev_we) consec_we++;
            if (!busy_o) stray_we++;
        end
        prev_we = mem_we_o;
    end

    function automatic bit legal(input logic [31:0] w);
        return !CHK || (w[31:26] == 6'b000000) || (w[31:26] == 6'b001000);
    endfunction

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        consec_we = 0;
        stray_we = 0;
        to_cnt = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            byte_valid_i = 1'b0;
            byte_i = 8'($urandom);
        end
        @(negedge clk);
        byte_i = b;
        byte_valid_i = 1'b1;
        t = 0;
        while (!byte_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready_o) begin
            to_cnt++;
            byte_valid_i = 1'b0;
        end else begin
            @(posedge clk);
            #1 byte_valid_i = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge clk);
        while (!done_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!done_o) to_cnt++;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        start_i = 1'b1;
        byte_valid_i = 1'b1;
        byte_i = 8'hA5;
        repeat (3) @(negedge clk);
        checks++;
        if ({byte_ready_o, mem_we_o, mem_addr_o, mem_data_o, word_cnt_o, busy_o, done_o, err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b we=%b addr=%h data=%h cnt=%0d busy=%b done=%b err=%b, want all 0",
                     byte_ready_o, mem_we_o, mem_addr_o, mem_data_o, word_cnt_o, busy_o, done_o, err_o);
        end
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        clear_mon();
        $display("test_reset: outputs after reset checked");
    endtask

    task automatic test_basic();
        clear_mon();
        do_start();
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0 || byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: busy=%b done=%b ready=%b, want 1 0 1", busy_o, done_o, byte_ready_o);
        end
        send_word(32'h0022_4020, 0);
        send_word(32'hFFFF_FFFF, 0);
        wait_done();
        checks++;
        if (wr_addr_q.size() !== 1 || to_cnt !== 0) begin
            errors++;
            $display("FAIL basic_writes: got %0d writes, %0d timeouts, want 1 write", wr_addr_q.size(), to_cnt);
        end else begin
            checks++;
            if (wr_addr_q[0] !== '0 || wr_data_q[0] !== 32'h0022_4020) begin
                errors++;
                $display("FAIL basic_word: got addr=%h data=%h, want addr=0 data=00224020", wr_addr_q[0], wr_data_q[0]);
            end
        end
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || word_cnt_o !== 3'd1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: got done=%b busy=%b cnt=%0d err=%b, want 1 0 1 0", done_o, busy_o, word_cnt_o, err_o);
        end
        $display("test_basic: write 00224020 at 0, %0d writes seen", wr_addr_q.size());
    endtask

    task automatic test_gaps();
        clear_mon();
        do_start();
        send_word(32'h2108_0003, 3);
        send_word(32'hFFFF_FFFF, 3);
        wait_done();
        checks++;
        if (wr_addr_q.size() !== 1 || to_cnt !== 0 || consec_we !== 0) begin
            errors++;
            $display("FAIL gaps_writes: got %0d writes, %0d timeouts, %0d double strobes, want 1 0 0",
                     wr_addr_q.size(), to_cnt, consec_we);
        end else begin
            checks++;
            if (wr_addr_q[0] !== '0 || wr_data_q[0] !== 32'h2108_0003) begin
                errors++;
                $display("FAIL gaps_word: got addr=%h data=%h, want addr=0 data=21080003", wr_addr_q[0], wr_data_q[0]);
            end
        end
        $display("test_gaps: valid gaps of 3 cycles, %0d writes seen", wr_addr_q.size());
    endtask

    task automatic test_full();
        logic [31:0] w;
        clear_mon();
        do_start();
        for (int i = 0; i < CAP; i++) begin
            w = 32'h2001_0005 + 32'(i);
            send_word(w, 0);
        end
        wait_done();
        checks++;
        if (wr_addr_q.size() !== CAP || to_cnt !== 0) begin
            errors++;
            $display("FAIL full_count: got %0d writes, %0d timeouts, want %0d", wr_addr_q.size(), to_cnt, CAP);
        end else begin
            for (int i = 0; i < CAP; i++) begin
                checks++;
                if (wr_addr_q[i] !== (ADDR_W+2)'(4 * i) || wr_data_q[i] !== 32'h2001_0005 + 32'(i)) begin
                    errors++;
                    $display("FAIL full_word%0d: got addr=%h data=%h, want addr=%h data=%h",
                             i, wr_addr_q[i], wr_data_q[i], 4 * i, 32'h2001_0005 + 32'(i));
                end
            end
        end
        checks++;
        if (done_o !== 1'b1 || word_cnt_o !== (ADDR_W+1)'(CAP) || mem_addr_o !== '0) begin
            errors++;
            $display("FAIL full_status: got done=%b cnt=%0d addr=%h, want 1 %0d 0", done_o, word_cnt_o, mem_addr_o, CAP);
        end
        byte_i = 8'h20;
        byte_valid_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (byte_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL full_ready: cycle %0d got ready=%b, want 0", c, byte_ready_o);
            end
        end
        byte_valid_i = 1'b0;
        checks++;
        if (wr_addr_q.size() !== CAP || word_cnt_o !== (ADDR_W+1)'(CAP)) begin
            errors++;
            $display("FAIL full_extra: got %0d writes cnt=%0d after extra byte, want %0d", wr_addr_q.size(), word_cnt_o, CAP);
        end
        $display("test_full: %0d words loaded, memory full", wr_addr_q.size());
    endtask

    task automatic test_reset_mid();
        clear_mon();
        do_start();
        send_word(32'h0000_1111, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || word_cnt_o !== '0 || byte_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: got busy=%b cnt=%0d ready=%b, want 0 0 0", busy_o, word_cnt_o, byte_ready_o);
        end
        rst_i = 1'b1;
        clear_mon();
        do_start();
        send_word(32'h2005_0077, 0);
        send_word(32'hFFFF_FFFF, 0);
        wait_done();
        checks++;
        if (wr_addr_q.size() !== 1 || to_cnt !== 0) begin
            errors++;
            $display("FAIL midreset_writes: got %0d writes, %0d timeouts, want 1", wr_addr_q.size(), to_cnt);
        end else begin
            checks++;
            if (wr_addr_q[0] !== '0 || wr_data_q[0] !== 32'h2005_0077) begin
                errors++;
                $display("FAIL midreset_word: got addr=%h data=%h, want addr=0 data=20050077", wr_addr_q[0], wr_data_q[0]);
            end
        end
        $display("test_reset_mid: reload after abort, %0d writes seen", wr_addr_q.size());
    endtask

    task automatic test_opcode();
        clear_mon();
        do_start();
        send_word(32'h8C22_0000, 0);
        if (!CHK) send_word(32'hFFFF_FFFF, 0);
        wait_done();
        checks++;
        if (wr_addr_q.size() !== (CHK ? 0 : 1) || err_o !== CHK || done_o !== 1'b1 || to_cnt !== 0) begin
            errors++;
            $display("FAIL opcode_lw: got %0d writes err=%b done=%b, want %0d writes err=%b done=1",
                     wr_addr_q.size(), err_o, done_o, CHK ? 0 : 1, CHK);
        end else if (!CHK) begin
            checks++;
            if (wr_addr_q[0] !== '0 || wr_data_q[0] !== 32'h8C22_0000) begin
                errors++;
                $display("FAIL opcode_word: got addr=%h data=%h, want addr=0 data=8c220000", wr_addr_q[0], wr_data_q[0]);
            end
        end
        $display("test_opcode: lw word, check=%0d, %0d writes, err=%b", CHK, wr_addr_q.size(), err_o);
    endtask

    task automatic test_start_mid();
        clear_mon();
        do_start();
        send_word(32'h0123_4567, 0);
        send_byte(8'h20, 0);
        send_byte(8'h0A, 0);
        do_start();
        send_byte(8'h0B, 0);
        send_byte(8'h0C, 0);
        send_word(32'hFFFF_FFFF, 0);
        wait_done();
        checks++;
        if (wr_addr_q.size() !== 2 || to_cnt !== 0 || word_cnt_o !== 3'd2) begin
            errors++;
            $display("FAIL startmid_count: got %0d writes cnt=%0d, want 2 2", wr_addr_q.size(), word_cnt_o);
        end else begin
            checks++;
            if (wr_addr_q[1] !== 4'h4 || wr_data_q[1] !== 32'h200A_0B0C) begin
                errors++;
                $display("FAIL startmid_word: got addr=%h data=%h, want addr=4 data=200a0b0c", wr_addr_q[1], wr_data_q[1]);
            end
        end
        $display("test_start_mid: start ignored during load, %0d writes seen", wr_addr_q.size());
    endtask

    task automatic test_random();
        logic [31:0] words[$];
        logic [ADDR_W+1:0] exp_addr[$];
        logic [31:0] exp_data[$];
        logic [31:0] w;
        logic [5:0] opc;
        bit exp_err;
        int n_send;
        int nw;
        for (int it = 0; it < 25; it++) begin
            words.delete();
            exp_addr.delete();
            exp_data.delete();
            nw = $urandom_range(1, CAP + 1);
            for (int i = 0; i < nw; i++) begin
                case ($urandom_range(0, 3))
                    0: opc = 6'b000000;
                    1: opc = 6'b001000;
                    default: opc = 6'($urandom);
                endcase
                w = {opc, 26'($urandom)};
                if (w == 32'hFFFF_FFFF) w = 32'h0;
                words.push_back(w);
            end
            words.push_back(32'hFFFF_FFFF);
            exp_err = 1'b0;
            n_send = 0;
            foreach (words[i]) begin
                n_send++;
                if (words[i] == 32'hFFFF_FFFF) break;
                if (!legal(words[i])) begin
                    exp_err = 1'b1;
                    break;
                end
                exp_addr.push_back((ADDR_W+2)'(4 * exp_addr.size()));
                exp_data.push_back(words[i]);
                if (exp_addr.size() == CAP) break;
            end
            clear_mon();
            do_start();
            for (int i = 0; i < n_send; i++) send_word(words[i], $urandom_range(0, 2));
            wait_done();
            checks++;
            if (wr_addr_q.size() !== exp_addr.size() || to_cnt !== 0) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d writes %0d timeouts, want %0d", it, wr_addr_q.size(), to_cnt, exp_addr.size());
            end else begin
                foreach (exp_addr[i]) begin
                    checks++;
                    if (wr_addr_q[i] !== exp_addr[i] || wr_data_q[i] !== exp_data[i]) begin
                        errors++;
                        $display("FAIL rand%0d_word%0d: got addr=%h data=%h, want addr=%h data=%h",
                                 it, i, wr_addr_q[i], wr_data_q[i], exp_addr[i], exp_data[i]);
                    end
                end
            end
            checks++;
            if (word_cnt_o !== (ADDR_W+1)'(exp_addr.size()) || err_o !== exp_err || done_o !== 1'b1 ||
                busy_o !== 1'b0 || consec_we !== 0 || stray_we !== 0) begin
                errors++;
                $display("FAIL rand%0d_status: got cnt=%0d err=%b done=%b busy=%b dbl=%0d stray=%0d, want cnt=%0d err=%b 1 0 0 0",
                         it, word_cnt_o, err_o, done_o, busy_o, consec_we, stray_we, exp_addr.size(), exp_err);
            end
            $display("test_random %0d: %0d words sent, %0d writes, err=%b", it, n_send, wr_addr_q.size(), err_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_full();
        test_reset_mid();
        test_opcode();
        test_start_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
